// File: rtl/fetch_decode.sv
// Fetch/decode front end: a step-tick paced FSM that fetches 16-bit words from a small
// program memory, decodes them and hands valid instructions to the ALU over a ready/valid pair.
module fetch_decode #(
   parameter int DIV_BITS = 26
) (
   input  logic        CLK_50,
   input  logic        RESET,
   input  logic        start,
   input  logic        prog_we,
   input  logic [3:0]  prog_addr,
   input  logic [15:0] prog_data,
   input  logic        issue_ready,
   output logic        issue_valid,
   output logic [3:0]  codop,
   output logic [3:0]  s4,
   output logic [3:0]  s3,
   output logic [3:0]  s2,
   output logic        sinal,
   output logic [3:0]  pc,
   output logic        busy,
   output logic        halted,
   output logic        illegal
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_FETCH  = 3'd1;
   localparam logic [2:0] S_DECODE = 3'd2;
   localparam logic [2:0] S_ISSUE  = 3'd3;
   localparam logic [2:0] S_HALT   = 3'd4;

   localparam logic [DIV_BITS-1:0] DIV_ONE = 1;
   localparam logic [3:0]          OP_HALT = 4'hF;
   localparam logic [3:0]          OP_LAST = 4'hA;

   logic [2:0]          state;
   logic [15:0]         mem [16];
   logic [15:0]         ir;
   logic [DIV_BITS-1:0] div_cnt;
   logic                tick;
   logic                prog_open;

   assign tick      = &div_cnt;
   assign prog_open = (state == S_IDLE) || (state == S_HALT);
   assign busy      = (state == S_FETCH) || (state == S_DECODE) || (state == S_ISSUE);

   // Program memory is deliberately outside reset so a reset never loses the loaded program.
   always_ff @(posedge CLK_50) begin
      if (!RESET && prog_we && prog_open) begin
         mem[prog_addr] <= prog_data;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + DIV_ONE;
      end
   end

   always_ff @(posedge CLK_50) begin
      if (RESET) begin
         state       <= S_IDLE;
         pc          <= 4'd0;
         ir          <= 16'd0;
         issue_valid <= 1'b0;
         sinal       <= 1'b0;
         halted      <= 1'b0;
         illegal     <= 1'b0;
         codop       <= 4'd0;
         s4          <= 4'd0;
         s3          <= 4'd0;
         s2          <= 4'd0;
      end else begin
         sinal <= 1'b0;
         case (state)
            S_IDLE, S_HALT: begin
               if (start) begin
                  pc      <= 4'd0;
                  halted  <= 1'b0;
                  illegal <= 1'b0;
                  state   <= S_FETCH;
               end
            end
            S_FETCH: begin
               if (tick) begin
                  ir    <= mem[pc];
                  state <= S_DECODE;
               end
            end
            S_DECODE: begin
               if (ir[15:12] == OP_HALT) begin
                  halted <= 1'b1;
                  state  <= S_HALT;
               end else if (ir[15:12] > OP_LAST) begin
                  // Reserved opcodes are skipped, never presented to the ALU.
                  illegal <= 1'b1;
                  pc      <= pc + 4'd1;
                  state   <= S_FETCH;
               end else begin
                  codop       <= ir[15:12];
                  s4          <= ir[11:8];
                  s3          <= ir[7:4];
                  s2          <= ir[3:0];
                  issue_valid <= 1'b1;
                  state       <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               if (issue_ready) begin
                  issue_valid <= 1'b0;
                  sinal       <= 1'b1;
                  pc          <= pc + 4'd1;
                  state       <= S_FETCH;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_decode.sv
// Directed and randomized checks of fetch_decode against a program-level reference walk.
module tb_fetch_decode;

   localparam int DIV_BITS = 2;

   logic        CLK_50 = 1'b0;
   logic        RESET = 1'b1;
   logic        start = 1'b0;
   logic        prog_we = 1'b0;
   logic [3:0]  prog_addr = 4'd0;
   logic [15:0] prog_data = 16'd0;
   logic        issue_ready = 1'b0;
   logic        issue_valid;
   logic [3:0]  codop, s4, s3, s2;
   logic        sinal;
   logic [3:0]  pc;
   logic        busy, halted, illegal;

   fetch_decode #(.DIV_BITS(DIV_BITS)) dut (
      .CLK_50(CLK_50), .RESET(RESET), .start(start), .prog_we(prog_we),
      .prog_addr(prog_addr), .prog_data(prog_data), .issue_ready(issue_ready),
      .issue_valid(issue_valid), .codop(codop), .s4(s4), .s3(s3), .s2(s2),
      .sinal(sinal), .pc(pc), .busy(busy), .halted(halted), .illegal(illegal)
   );

   always #5 CLK_50 = ~CLK_50;

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   logic [15:0] mem_model [16];
   logic [15:0] exp_q [$];
   logic [15:0] obs_q [$];
   logic        exp_halt, exp_ill;
   logic [3:0]  exp_pc;
   int          sinal_cnt;
   bit          wrap_seen;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Walk the program by its instruction semantics: halt stops, reserved codes skip, others issue.
   task automatic run_model();
      logic [3:0] p;
      logic [3:0] op;
      p = 4'd0;
      exp_q.delete();
      exp_halt = 1'b0;
      exp_ill  = 1'b0;
      for (int n = 0; n < 64 && !exp_halt; n++) begin
         op = mem_model[p][15:12];
         if (op == 4'hF) begin
            exp_halt = 1'b1;
         end else begin
            if (op >= 4'hB) exp_ill = 1'b1;
            else exp_q.push_back(mem_model[p]);
            p = p + 4'd1;
         end
      end
      exp_pc = p;
   endtask

   task automatic load_word(input logic [3:0] a, input logic [15:0] d);
      mem_model[a] = d;
      prog_addr = a;
      prog_data = d;
      prog_we = 1'b1;
      @(negedge CLK_50);
      prog_we = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge CLK_50);
      start = 1'b0;
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_valid"}, 32'(issue_valid), 32'd0);
      chk({tag, "_sinal"}, 32'(sinal), 32'd0);
      chk({tag, "_fields"}, 32'({codop, s4, s3, s2}), 32'd0);
      chk({tag, "_pc"}, 32'(pc), 32'd0);
      chk({tag, "_flags"}, 32'({busy, halted, illegal}), 32'd0);
   endtask

   // mode 0: ready always high; 1: random ready; 2: ready held low for five valid cycles.
   task automatic run_prog(input int mode, input bit expect_halt, input int budget);
      int          cyc;
      int          vcnt;
      bit          done, rdy, prev_hs, prev_wait;
      logic [15:0] prev_f;
      logic [3:0]  prev_pc;
      cyc = 0; vcnt = 0; done = 0; prev_hs = 0; prev_wait = 0;
      prev_f = 16'd0; prev_pc = pc;
      obs_q.delete();
      sinal_cnt = 0;
      wrap_seen = 0;
      while (!done && cyc < budget) begin
         @(negedge CLK_50);
         cyc++;
         chk("sinal_after_handshake", 32'(sinal), 32'(prev_hs));
         if (sinal) sinal_cnt++;
         if (prev_wait) begin
            chk("hold_valid", 32'(issue_valid), 32'd1);
            chk("hold_fields", 32'({codop, s4, s3, s2}), 32'(prev_f));
         end
         if (prev_pc == 4'd15 && pc == 4'd0) wrap_seen = 1;
         prev_pc = pc;
         if (halted === 1'b1) begin
            done = 1;
         end else begin
            case (mode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: rdy = (vcnt >= 5);
            endcase
            issue_ready = rdy;
            vcnt = issue_valid ? vcnt + 1 : 0;
            prev_hs   = issue_valid && rdy;
            prev_wait = issue_valid && !rdy;
            prev_f    = {codop, s4, s3, s2};
            if (prev_hs) obs_q.push_back(prev_f);
         end
      end
      issue_ready = 1'b0;
      for (int i = 0; i < obs_q.size(); i++) begin
         if (i < exp_q.size()) chk("issue_word", 32'(obs_q[i]), 32'(exp_q[i]));
         else chk("issue_extra", 32'(obs_q.size()), 32'(exp_q.size()));
      end
      if (expect_halt) begin
         chk("halt_within_budget", 32'(done), 32'd1);
         chk("issue_count", 32'(obs_q.size()), 32'(exp_q.size()));
         chk("sinal_count", 32'(sinal_cnt), 32'(exp_q.size()));
         chk("halted", 32'(halted), 32'(exp_halt));
         chk("final_pc", 32'(pc), 32'(exp_pc));
         chk("illegal", 32'(illegal), 32'(exp_ill));
         chk("busy_halt", 32'(busy), 32'd0);
      end
   endtask

   initial begin
      int          w;
      logic [15:0] rnd;
      repeat (3) @(negedge CLK_50);
      chk_zero("reset");
      RESET = 1'b0;

      // Basic handshake then halt.
      load_word(4'd0, 16'h0321);
      load_word(4'd1, 16'hF000);
      run_model();
      pulse_start();
      run_prog(0, 1, 200);

      // Stall for five cycles under a held instruction.
      load_word(4'd0, 16'h1456);
      run_model();
      pulse_start();
      run_prog(2, 1, 200);

      // Reserved opcode is skipped and flagged.
      load_word(4'd0, 16'hC000);
      run_model();
      pulse_start();
      run_prog(0, 1, 200);

      // Reset wins over start and prog_we while halted.
      RESET = 1'b1; start = 1'b1; prog_we = 1'b1; prog_addr = 4'd0; prog_data = 16'h3333;
      @(negedge CLK_50);
      RESET = 1'b0; start = 1'b0; prog_we = 1'b0;
      chk_zero("reset_prio");
      @(negedge CLK_50);
      chk("reset_prio_idle", 32'(busy), 32'd0);
      run_model();
      pulse_start();
      run_prog(1, 1, 200);

      // Write and start in the same idle cycle: the fetch sees the new word.
      mem_model[0] = 16'h0ABC;
      prog_addr = 4'd0; prog_data = 16'h0ABC; prog_we = 1'b1; start = 1'b1;
      @(negedge CLK_50);
      prog_we = 1'b0; start = 1'b0;
      run_model();
      run_prog(1, 1, 200);

      // A write while fetching is ignored.
      load_word(4'd0, 16'h0321);
      run_model();
      pulse_start();
      chk("fetch_busy", 32'(busy), 32'd1);
      prog_addr = 4'd0; prog_data = 16'h5A5A; prog_we = 1'b1;
      @(negedge CLK_50);
      prog_we = 1'b0;
      run_prog(0, 1, 200);

      // Random programs, each with a guaranteed halt somewhere in memory.
      for (int r = 0; r < 5; r++) begin
         w = $urandom_range(0, 15);
         for (int a = 0; a < 16; a++) begin
            rnd = 16'($urandom);
            if (a == w) rnd[15:12] = 4'hF;
            load_word(4'(a), rnd);
         end
         run_model();
         pulse_start();
         run_prog(r % 3, 1, 600);
      end

      // Reset while an instruction is waiting for the ALU.
      load_word(4'd0, 16'h2000);
      load_word(4'd1, 16'hF000);
      pulse_start();
      issue_ready = 1'b0;
      w = 0;
      while (issue_valid !== 1'b1 && w < 40) begin
         @(negedge CLK_50);
         w++;
      end
      chk("reach_issue", 32'(issue_valid), 32'd1);
      RESET = 1'b1;
      @(negedge CLK_50);
      RESET = 1'b0;
      chk_zero("reset_in_issue");
      run_model();
      pulse_start();
      run_prog(0, 1, 200);

      // Sixteen ALU words: execution wraps the pc and keeps going.
      for (int a = 0; a < 16; a++) load_word(4'(a), 16'h0111);
      run_model();
      pulse_start();
      run_prog(0, 0, 80);
      chk("wrap_seen", 32'(wrap_seen), 32'd1);
      chk("wrap_enough_pulses", 32'(sinal_cnt >= 17), 32'd1);
      chk("wrap_still_busy", 32'(busy), 32'd1);
      chk("wrap_no_flags", 32'({halted, illegal}), 32'd0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
